// File: rtl/iir_decim_fifo.sv
// Block-averaging decimator with saturation, feeding a show-ahead FIFO.
// Ports: clk, rst_n, in_valid/in_data, out_valid/out_ready/out_data, count, ovf, ovf_clr.
module iir_decim_fifo #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [IN_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int SH  = $clog2(DECIM);
  localparam int AW  = IN_W + SH;
  localparam int PW  = (SH > 0) ? SH : 1;
  localparam int PTR = $clog2(DEPTH);
  localparam int CW  = PTR + 1;

  localparam logic signed [AW-1:0] MAXV = AW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = AW'(-(1 << (OUT_W - 1)));

  logic signed [AW-1:0]    acc_q, acc_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    shifted;
  logic signed [OUT_W-1:0] res;
  logic                    last;
  logic                    push;

  logic [OUT_W-1:0]        mem [DEPTH];
  logic [PTR-1:0]          wptr_q, wptr_d;
  logic [PTR-1:0]          rptr_q, rptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    empty, full, pop, push_ok;

  assign last    = (phase_q == PW'(DECIM - 1));
  assign sum     = acc_q + AW'(in_data);
  // Arithmetic shift floors toward -inf.
  assign shifted = sum >>> SH;

  always_comb begin
    res = shifted[OUT_W-1:0];
    if (shifted > MAXV) res = MAXV[OUT_W-1:0];
    else if (shifted < MINV) res = MINV[OUT_W-1:0];
  end

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    push    = 1'b0;
    if (in_valid) begin
      if (last) begin
        acc_d   = '0;
        phase_d = '0;
        push    = 1'b1;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + PW'(1);
      end
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = !empty && out_ready;
  // A full FIFO still takes a push when the head leaves this cycle.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wptr_d  = push_ok ? wptr_q + PTR'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PTR'(1) : rptr_q;
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = (ovf_q && !ovf_clr) || (push && full && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      phase_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= res;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rptr_q];
  assign count     = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_iir_decim_fifo.sv
// Directed scoreboard bench for iir_decim_fifo.
// Instance a: DECIM=4, OUT_W=8; instance b: DECIM=1, OUT_W=16.
module tb_iir_decim_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               va = 0, ra = 0, ca = 0;
  logic signed [15:0] da = 0;
  logic               ova, ovfa;
  logic signed [7:0]  oda;
  logic [2:0]         cnta;

  logic               vb = 0, rb = 0, cb = 0;
  logic signed [15:0] db = 0;
  logic               ovb, ovfb;
  logic signed [15:0] odb;
  logic [2:0]         cntb;

  iir_decim_fifo #(.IN_W(16), .OUT_W(8), .DECIM(4), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(da),
    .out_valid(ova), .out_ready(ra), .out_data(oda),
    .count(cnta), .ovf(ovfa), .ovf_clr(ca)
  );

  iir_decim_fifo #(.IN_W(16), .OUT_W(16), .DECIM(1), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(db),
    .out_valid(ovb), .out_ready(rb), .out_data(odb),
    .count(cntb), .ovf(ovfb), .ovf_clr(cb)
  );

  int n_chk = 0;
  int n_err = 0;
  int qa[$];
  int qb[$];
  int vcnt_a = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pop monitors: each accepted head is compared with the scoreboard.
  always @(negedge clk) begin
    if (ova) vcnt_a++;
    if (ova && ra) begin
      if (qa.size() == 0) chk("a_unexpected_pop", int'(oda), 9999);
      else chk("a_pop", int'(oda), qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ovb && rb) begin
      if (qb.size() == 0) chk("b_unexpected_pop", int'(odb), 9999);
      else chk("b_pop", int'(odb), qb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input int x);
    va = 1'b1;
    da = 16'(x);
    step();
    va = 1'b0;
  endtask

  task automatic feed_b(input int x);
    vb = 1'b1;
    db = 16'(x);
    step();
    vb = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_count_a", int'(cnta), 0);
    chk("rst_valid_a", int'(ova), 0);
    chk("rst_data_a", int'(oda), 0);
    chk("rst_ovf_a", int'(ovfa), 0);
    chk("rst_count_b", int'(cntb), 0);
    chk("rst_valid_b", int'(ovb), 0);
    step();
    rst_n = 1'b1;
    step();

    // Filter output stream, ready held high
    ra = 1'b1;
    vcnt_a = 0;
    feed_a(18); feed_a(0); feed_a(18);
    qa.push_back(3);
    va = 1'b1; da = -16'sd21;
    step();
    va = 1'b0;
    @(negedge clk);
    chk("lat_valid", int'(ova), 1);
    chk("lat_data", int'(oda), 3);
    step();
    feed_a(69); feed_a(-93); feed_a(219);
    qa.push_back(-50);
    feed_a(-393);
    step(); step();
    chk("valid_cycles", vcnt_a, 2);

    // Saturation at OUT_W=8
    repeat (4) feed_a(32767);
    qa.push_back(127);
    repeat (4) feed_a(-32768);
    qa.push_back(-128);
    repeat (4) feed_a(100);
    qa.push_back(100);
    step(); step();
    chk("sat_drained", int'(cnta), 0);

    // Overflow: fill, then drop while ovf_clr is pulsed (set wins)
    rb = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      qb.push_back(i);
      feed_b(i);
    end
    chk("full_count", int'(cntb), 4);
    chk("full_no_ovf", int'(ovfb), 0);
    chk("full_head", int'(odb), 1);
    cb = 1'b1;
    feed_b(5);
    cb = 1'b0;
    chk("ovf_set_wins", int'(ovfb), 1);
    chk("ovf_count", int'(cntb), 4);
    chk("ovf_head_kept", int'(odb), 1);
    step();
    chk("ovf_sticky", int'(ovfb), 1);
    cb = 1'b1;
    step();
    cb = 1'b0;
    chk("ovf_cleared", int'(ovfb), 0);

    // Full FIFO with simultaneous pop and push
    rb = 1'b1;
    qb.push_back(9);
    feed_b(9);
    chk("fullpop_count", int'(cntb), 4);
    chk("fullpop_ovf", int'(ovfb), 0);
    chk("fullpop_head", int'(odb), 2);
    repeat (5) step();
    chk("drain_empty", int'(cntb), 0);
    chk("drain_data0", int'(odb), 0);

    // Reset mid-group discards the partial sum
    feed_a(100); feed_a(100);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", int'(cnta), 0);
    chk("midrst_valid", int'(ova), 0);
    step();
    rst_n = 1'b1;
    step();
    repeat (3) feed_a(4);
    qa.push_back(4);
    feed_a(4);
    step(); step();

    // Gapped input
    for (int i = 0; i < 4; i++) begin
      if (i == 3) qa.push_back(8);
      feed_a(8);
      step();
    end
    repeat (4) step();

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("end_count_a", int'(cnta), 0);
    chk("end_ovf_a", int'(ovfa), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
